// File: rtl/mem_access_controller.sv
// rtl/mem_access_controller.sv - MEM-stage load/store sequencer for a 16-bit external SRAM
//
// Each 32-bit load or store becomes two timed halfword accesses: low half, then high half.
// Each halfword is held on the SRAM pins for WAIT_CYCLES cycles. ready stays low while a
// request is pending, so the pipeline freezes on ~ready.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-low reset
//   mem_r_en     load request from MEM stage
//   mem_w_en     store request from MEM stage (wins over mem_r_en)
//   address      32-bit byte address (ALU result)
//   write_data   32-bit store data
//   read_data    registered load result; changes only at read completion
//   ready        1 = no request pending, or access completing this cycle
//   sram_addr    18-bit SRAM halfword address {word_index[16:0], half}
//   sram_dq_out  halfword write data
//   sram_dq_oe   1 = drive sram_dq_out onto the SRAM data bus
//   sram_dq_in   halfword read data from the SRAM
//   sram_we_n    SRAM write enable, active low
module mem_access_controller #(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  localparam int            CW   = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          op_write;
  logic [16:0]   idx_q;
  logic [31:0]   data_q;
  logic [15:0]   lower_q;

  // Offset from the SRAM window base. It wraps modulo 2^32, so addresses below
  // BASE_ADDR land at the top of the 17-bit word index space.
  logic [31:0] offset;
  logic        unused_offset_bits;
  assign offset             = address - BASE_ADDR;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  wire last = (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_write  <= 1'b0;
      idx_q     <= '0;
      data_q    <= '0;
      lower_q   <= '0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_r_en | mem_w_en) begin
            op_write <= mem_w_en;
            idx_q    <= offset[18:2];
            data_q   <= write_data;
            cnt      <= '0;
            state    <= LOW;
          end
        end
        LOW: begin
          if (last) begin
            cnt   <= '0;
            state <= HIGH;
            if (!op_write) lower_q <= sram_dq_in;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (last) begin
            cnt   <= '0;
            state <= DONE;
            if (!op_write) read_data <= {sram_dq_in, lower_q};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;  // DONE never starts a new request
      endcase
    end
  end

  // SRAM pins decode from registered state only, so mid-access input changes
  // cannot glitch them.
  wire active = (state == LOW) || (state == HIGH);
  wire wr_act = op_write && active;

  always_comb begin
    sram_addr   = {idx_q, (state == HIGH)};
    sram_dq_oe  = wr_act;
    sram_we_n   = ~wr_act;
    sram_dq_out = 16'h0000;
    if (wr_act) sram_dq_out = (state == HIGH) ? data_q[31:16] : data_q[15:0];
  end

  assign ready = ~(mem_r_en | mem_w_en) | (state == DONE);

endmodule

// File: tb/tb_mem_access_controller.sv
// tb/tb_mem_access_controller.sv - directed self-checking bench for mem_access_controller
module tb_mem_access_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic        r1, w1;
  logic [31:0] a1, d1, rd1;
  logic        ready1;
  logic [17:0] sa1;
  logic [15:0] dq_out1;
  logic [15:0] dq_in1 = 16'hA5A5;
  logic        oe1, we_n1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_controller #(.WAIT_CYCLES(5), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  mem_access_controller #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut1 (
    .clk(clk), .rst(rst), .mem_r_en(r1), .mem_w_en(w1),
    .address(a1), .write_data(d1), .read_data(rd1), .ready(ready1),
    .sram_addr(sa1), .sram_dq_out(dq_out1), .sram_dq_oe(oe1),
    .sram_dq_in(dq_in1), .sram_we_n(we_n1)
  );

  // SRAM model: unwritten halfwords read back as {8'h5A, addr[7:0]}.
  logic [15:0]  mem [0:255];
  logic [255:0] vld = '0;
  always @(posedge clk) begin
    if (!sram_we_n) begin
      mem[sram_addr[7:0]] <= sram_dq_out;
      vld[sram_addr[7:0]] <= 1'b1;
    end
  end
  assign sram_dq_in = vld[sram_addr[7:0]] ? mem[sram_addr[7:0]] : {8'h5A, sram_addr[7:0]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    @(negedge clk);
    check({tag, " idle_ready"}, ready, 1);
    next();
  endtask

  // Entered at posedge+1 with the FSM in IDLE; leaves at posedge+1 of the next IDLE cycle.
  task automatic access(input string tag, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [17:0] base, input logic [31:0] exp_rd);
    mem_r_en = r; mem_w_en = w; address = a; write_data = d;
    @(negedge clk);
    check({tag, " ready_t0"}, ready, 0);
    for (int i = 1; i <= 10; i++) begin
      next();
      @(negedge clk);
      check($sformatf("%s addr c%0d", tag, i), sram_addr, base + (i > 5 ? 18'd1 : 18'd0));
      check($sformatf("%s we_n c%0d", tag, i), sram_we_n, !w);
      check($sformatf("%s oe c%0d", tag, i), sram_dq_oe, w);
      check($sformatf("%s dq c%0d", tag, i), sram_dq_out,
            w ? (i <= 5 ? d[15:0] : d[31:16]) : 16'h0000);
      check($sformatf("%s ready c%0d", tag, i), ready, 0);
    end
    next();
    @(negedge clk);
    check({tag, " done_ready"}, ready, 1);
    check({tag, " done_we_n"}, sram_we_n, 1);
    check({tag, " done_addr"}, sram_addr, base);
    check({tag, " read_data"}, read_data, exp_rd);
    next();
  endtask

  initial begin
    rst = 1'b0;
    mem_r_en = 1'b0; mem_w_en = 1'b0; address = '0; write_data = '0;
    r1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst read_data", read_data, 0);
    check("rst we_n", sram_we_n, 1);
    check("rst oe", sram_dq_oe, 0);
    check("rst addr", sram_addr, 0);
    check("rst ready", ready, 1);
    check("rst ready w1", ready1, 1);
    next();
    rst = 1'b1;
    next();

    access("st1032", 0, 1, 32'd1032, 32'hDEADBEEF, 18'd4, 32'h0);
    idle("st1032");
    access("ld1032", 1, 0, 32'd1032, 32'h0, 18'd4, 32'hDEADBEEF);
    idle("ld1032");
    access("ld1024", 1, 0, 32'd1024, 32'h0, 18'd0, 32'h5A015A00);
    access("ld1028", 1, 0, 32'd1028, 32'h0, 18'd2, 32'h5A035A02);
    idle("b2b");
    access("rw1040", 1, 1, 32'd1040, 32'h12345678, 18'd8, 32'h5A035A02);
    idle("rw1040");
    access("ld1040", 1, 0, 32'd1040, 32'h0, 18'd8, 32'h12345678);
    idle("ld1040");
    access("st1020", 0, 1, 32'd1020, 32'hCAFEF00D, 18'h3FFFE, 32'h12345678);
    idle("st1020");
    access("ld1020", 1, 0, 32'd1020, 32'h0, 18'h3FFFE, 32'hCAFEF00D);
    idle("ld1020");

    // Address changes and request drops during LOW: access finishes on 1024.
    mem_r_en = 1'b1; address = 32'd1024;
    @(negedge clk);
    check("mid ready_t0", ready, 0);
    for (int i = 1; i <= 10; i++) begin
      next();
      if (i == 2) begin
        mem_r_en = 1'b0;
        address  = 32'd1032;
      end
      @(negedge clk);
      check($sformatf("mid addr c%0d", i), sram_addr, i > 5 ? 18'd1 : 18'd0);
    end
    next();
    @(negedge clk);
    check("mid read_data", read_data, 32'h5A015A00);
    next();

    // Reset during HIGH of a store at 1048 (halfwords 12/13).
    mem_w_en = 1'b1; address = 32'd1048; write_data = 32'hAAAA5555;
    repeat (7) next();
    @(negedge clk);
    check("rstmid pre we_n", sram_we_n, 0);
    check("rstmid pre addr", sram_addr, 18'd13);
    #1 rst = 1'b0;
    #1;
    check("rstmid we_n", sram_we_n, 1);
    check("rstmid oe", sram_dq_oe, 0);
    check("rstmid addr", sram_addr, 0);
    check("rstmid read_data", read_data, 0);
    mem_w_en = 1'b0;
    next();
    rst = 1'b1;
    @(negedge clk);
    check("rstmid idle we_n", sram_we_n, 1);
    check("rstmid idle ready", ready, 1);
    next();

    // WAIT_CYCLES = 1: ready high three cycles after the request.
    r1 = 1'b1; a1 = 32'd1024;
    @(negedge clk);
    check("w1 rd ready t0", ready1, 0);
    next(); @(negedge clk);
    check("w1 rd ready t1", ready1, 0);
    check("w1 rd addr t1", sa1, 18'd0);
    next(); @(negedge clk);
    check("w1 rd ready t2", ready1, 0);
    check("w1 rd addr t2", sa1, 18'd1);
    next(); @(negedge clk);
    check("w1 rd ready t3", ready1, 1);
    check("w1 read_data", rd1, 32'hA5A5A5A5);
    next();
    r1 = 1'b0; w1 = 1'b1; d1 = 32'h00020001;
    @(negedge clk);
    check("w1 wr ready t0", ready1, 0);
    next(); @(negedge clk);
    check("w1 wr we_n t1", we_n1, 0);
    check("w1 wr dq t1", dq_out1, 16'h0001);
    next(); @(negedge clk);
    check("w1 wr oe t2", oe1, 1);
    check("w1 wr dq t2", dq_out1, 16'h0002);
    next(); @(negedge clk);
    check("w1 wr ready t3", ready1, 1);
    check("w1 wr we_n t3", we_n1, 1);
    next();
    w1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_controller.md
# mem_access_controller

Sequences every MEM-stage load/store onto a 16-bit-wide external SRAM. Translates the 32-bit byte address from the pipeline into an SRAM halfword address and splits each 32-bit word into two timed halfword accesses. Holds `ready` low while an access is in flight so the hazard/freeze logic can stall the pipeline. Sits between the MEM stage and the SRAM pins, replacing the single-cycle on-chip data memory path.

## Interface

- `WAIT_CYCLES`, 5: cycles each halfword phase is held on the SRAM pins (≥1)
- `BASE_ADDR`, 1024: byte address that maps to SRAM word 0
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `mem_r_en` in 1: load request from MEM stage
- `mem_w_en` in 1: store request from MEM stage
- `address` in 32: byte address (ALU result)
- `write_data` in 32: store data
- `read_data` out 32: registered load result
- `ready` out 1: 1 = no access pending or access completing this cycle; freeze = ~ready
- `sram_addr` out 18: SRAM halfword address
- `sram_dq_out` out 16: write data to SRAM
- `sram_dq_oe` out 1: 1 = drive `sram_dq_out` onto the bus
- `sram_dq_in` in 16: read data from SRAM
- `sram_we_n` out 1: SRAM write enable, active low

## Operation

- States: IDLE, LOW, HIGH, DONE; a wait counter of width clog2(WAIT_CYCLES)+1.
- IDLE: if `mem_r_en | mem_w_en`, latch op (write if `mem_w_en`, else read; both high = write), latch `address` and `write_data`, clear counter, go to LOW.
- Word index = (latched address − BASE_ADDR) >> 2, computed modulo 2^32 and truncated to 17 bits. `sram_addr` = {index[16:0], half}; half = 0 in LOW, 1 in HIGH, 0 in IDLE/DONE.
- LOW/HIGH: counter increments each cycle. On the cycle counter == WAIT_CYCLES−1, advance LOW→HIGH or HIGH→DONE and clear counter.
- Write: `sram_dq_out` = data[15:0] in LOW and data[31:16] in HIGH. `sram_dq_oe` = 1 and `sram_we_n` = 0 for every LOW/HIGH cycle. Otherwise `sram_we_n` = 1, `sram_dq_oe` = 0, `sram_dq_out` = 0.
- Read: on the last cycle of LOW, capture `sram_dq_in` into a lower-half register. On the last cycle of HIGH, load `read_data` = {sram_dq_in, lower_half}.
- `read_data` holds its value through writes and idle; it changes only at read completion.
- DONE: one cycle, then unconditionally go to IDLE. A new request is never started from DONE.
- `ready` = ~(mem_r_en | mem_w_en) | (state == DONE), combinational.
- SRAM outputs decode from registered state, op and counter only; they never depend on `address` or `write_data` inputs directly.
- Latched address and data are immune to input changes mid-access. A request deasserted mid-access does not abort it; the access completes.
- Reset (`rst` = 0, any time, including mid-access): state IDLE, counter 0, `read_data` 0, lower-half 0, latches 0. This forces `sram_we_n` = 1, `sram_dq_oe` = 0 and `sram_addr` = 0 immediately.

## Timing

- Request first seen in IDLE at cycle t (`ready` = 0 that cycle):
  - LOW occupies t+1 … t+W.
  - HIGH occupies t+W+1 … t+2W.
  - DONE is t+2W+1, with `ready` = 1.
- Total stall is 2W+1 cycles; the instruction leaves MEM at the edge ending t+2W+1. With W = 5: `ready` low for 11 cycles, high on the 12th.
- `read_data` is valid from the start of DONE. It must be sampled by MEM/WB at the end of DONE.
- Back-to-back requests: DONE → IDLE → LOW, so there is one IDLE cycle (`ready` = 0) between accesses.
- With no request, `ready` = 1 and the FSM stays in IDLE.

## Test plan

- Reset: hold `rst` = 0 → `read_data` = 0, `sram_we_n` = 1, `sram_dq_oe` = 0, `sram_addr` = 0, `ready` = 1.
- Store: W = 5, `mem_w_en` = 1, `address` = 1032, `write_data` = 0xDEADBEEF → `sram_addr` = 4 with dq 0xBEEF for 5 cycles, then `sram_addr` = 5 with dq 0xDEAD for 5 cycles; `sram_we_n` low for 10 cycles; `ready` rises exactly 11 cycles after request.
- Load: the SRAM model returns the stored halfwords; `mem_r_en` = 1, `address` = 1032 → `read_data` = 0xDEADBEEF in DONE; `sram_we_n` stays 1.
- Back-to-back and simultaneous requests:
  - Load at 1024 followed immediately by a load at 1028 → `sram_addr` sequence 0,1 then 2,3, with one IDLE cycle between.
  - `mem_r_en` = `mem_w_en` = 1 → write performed.
- Mid-access disturbance:
  - Change `address` and drop `mem_r_en` during LOW → access still completes on the original address.
  - Assert `rst` during HIGH of a store → `sram_we_n` = 1 immediately, FSM in IDLE, `read_data` = 0.
- Boundary: `address` = 1020 (below BASE) → index wraps, `sram_addr` = {17'h1FFFF, half}. W = 1 → `ready` high 3 cycles after request.
